// File: rtl/rr_request_driver.sv
// rr_request_driver: per-client pending-job counters feeding an rr_arbiter.
// Drives request from the counters and retires jobs on accepted one-hot grants.
// Flags illegal grants, counter overflow and round-robin starvation as sticky errors.
module rr_request_driver #(
    parameter int unsigned CLIENTS = 32,
    parameter int unsigned CNT_W   = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [CLIENTS-1:0]                push,
    output logic [CLIENTS-1:0]                push_ready,
    output logic [CLIENTS-1:0]                request,
    input  logic [CLIENTS-1:0]                grant,
    input  logic                              stall,
    output logic [CLIENTS-1:0]                served,
    output logic [CNT_W+$clog2(CLIENTS)-1:0]  pending_total,
    output logic                              err_onehot,
    output logic                              err_unreq,
    output logic                              err_overflow,
    output logic                              err_starve
);

    localparam int unsigned PT_W  = CNT_W + $clog2(CLIENTS);
    localparam int unsigned AGE_W = $clog2(CLIENTS) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(CLIENTS);

    logic [CNT_W-1:0]   count_q [CLIENTS];
    logic [CNT_W-1:0]   count_d [CLIENTS];
    logic [AGE_W-1:0]   age_q   [CLIENTS];
    logic [AGE_W-1:0]   age_d   [CLIENTS];
    logic [CLIENTS-1:0] served_q, served_d;
    logic               err_onehot_q, err_onehot_d;
    logic               err_unreq_q, err_unreq_d;
    logic               err_overflow_q, err_overflow_d;
    logic               err_starve_q, err_starve_d;

    logic               acc;
    logic               grant_onehot;
    logic [CLIENTS-1:0] retire;
    logic [CLIENTS-1:0] inc;

    // Outputs derived purely from registered state
    always_comb begin
        pending_total = '0;
        for (int unsigned i = 0; i < CLIENTS; i++) begin
            request[i]    = (count_q[i] != '0);
            push_ready[i] = (count_q[i] != CNT_MAX);
            pending_total = pending_total + PT_W'(count_q[i]);
        end
        served       = served_q;
        err_onehot   = err_onehot_q;
        err_unreq    = err_unreq_q;
        err_overflow = err_overflow_q;
        err_starve   = err_starve_q;
    end

    // Grant qualification, counter/age next state and sticky error updates
    always_comb begin
        acc          = !stall && (grant != '0);
        grant_onehot = ((grant & (grant - 1'b1)) == '0);
        retire       = '0;
        inc          = '0;
        served_d     = '0;
        err_onehot_d   = err_onehot_q   || (acc && !grant_onehot);
        err_unreq_d    = err_unreq_q    || (acc && ((grant & ~request) != '0));
        err_overflow_d = err_overflow_q || ((push & ~push_ready) != '0);
        err_starve_d   = err_starve_q;
        for (int unsigned i = 0; i < CLIENTS; i++) begin
            retire[i]   = acc && grant_onehot && grant[i] && request[i];
            inc[i]      = push[i] && push_ready[i];
            served_d[i] = retire[i];
            count_d[i]  = count_q[i];
            if (inc[i] && !retire[i])
                count_d[i] = count_q[i] + 1'b1;
            else if (retire[i] && !inc[i])
                count_d[i] = count_q[i] - 1'b1;
            // Only one-hot accepted grants consume an arbitration slot for ageing;
            // a retire or an emptied counter restarts the wait.
            age_d[i] = age_q[i];
            if (retire[i] || (count_d[i] == '0))
                age_d[i] = '0;
            else if (acc && grant_onehot && request[i] && !grant[i] && (age_q[i] != AGE_LIMIT))
                age_d[i] = age_q[i] + 1'b1;
            if (age_d[i] == AGE_LIMIT)
                err_starve_d = 1'b1;
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < CLIENTS; i++) begin
                count_q[i] <= '0;
                age_q[i]   <= '0;
            end
            served_q       <= '0;
            err_onehot_q   <= 1'b0;
            err_unreq_q    <= 1'b0;
            err_overflow_q <= 1'b0;
            err_starve_q   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < CLIENTS; i++) begin
                count_q[i] <= count_d[i];
                age_q[i]   <= age_d[i];
            end
            served_q       <= served_d;
            err_onehot_q   <= err_onehot_d;
            err_unreq_q    <= err_unreq_d;
            err_overflow_q <= err_overflow_d;
            err_starve_q   <= err_starve_d;
        end
    end

endmodule

// File: tb/tb_rr_request_driver.sv
// Directed bench for rr_request_driver with hand-computed expectations.
module tb_rr_request_driver;

    localparam int unsigned CLIENTS = 32;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned PT_W    = CNT_W + $clog2(CLIENTS);

    logic               clock = 1'b0;
    logic               reset;
    logic [CLIENTS-1:0] push;
    logic [CLIENTS-1:0] push_ready;
    logic [CLIENTS-1:0] request;
    logic [CLIENTS-1:0] grant;
    logic               stall;
    logic [CLIENTS-1:0] served;
    logic [PT_W-1:0]    pending_total;
    logic               err_onehot, err_unreq, err_overflow, err_starve;

    int total = 0;
    int bad   = 0;

    rr_request_driver #(.CLIENTS(CLIENTS), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .push(push), .push_ready(push_ready),
        .request(request), .grant(grant), .stall(stall), .served(served),
        .pending_total(pending_total), .err_onehot(err_onehot), .err_unreq(err_unreq),
        .err_overflow(err_overflow), .err_starve(err_starve)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; push = '0; grant = '0; stall = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [3:0] errs();
        return {err_onehot, err_unreq, err_overflow, err_starve};
    endfunction

    initial begin
        reset = 1'b1; push = '0; grant = '0; stall = 1'b0;
        do_reset();
        check("rst_request", request, 0);
        check("rst_pending", pending_total, 0);
        check("rst_push_ready", push_ready, 32'hFFFF_FFFF);
        check("rst_served", served, 0);
        check("rst_errs", errs(), 0);

        // Reset in the middle of a burst discards jobs
        push = 32'h8;
        repeat (3) tick();
        check("burst_pending", pending_total, 3);
        check("burst_request", request, 32'h8);
        reset = 1'b1; push = '0;
        tick();
        reset = 1'b0;
        check("midrst_request", request, 0);
        check("midrst_pending", pending_total, 0);
        check("midrst_errs", errs(), 0);
        tick();
        check("midrst_served", served, 0);

        // Basic retire
        do_reset();
        push = 32'h20;
        tick();
        push = '0;
        check("basic_request", request, 32'h20);
        check("basic_pending", pending_total, 1);
        grant = 32'h20;
        tick();
        grant = '0;
        check("basic_served", served, 32'h20);
        check("basic_request_drop", request, 0);
        check("basic_pending_zero", pending_total, 0);
        tick();
        check("basic_served_clear", served, 0);
        check("basic_errs", errs(), 0);

        // Stall holds grants off
        do_reset();
        push = 32'h1;
        repeat (2) tick();
        push = '0;
        check("stall_pending_pre", pending_total, 2);
        grant = 32'h1; stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_pending_hold", pending_total, 2);
            check("stall_served_zero", served, 0);
        end
        stall = 1'b0;
        tick();
        check("stall_served1", served, 32'h1);
        check("stall_pending1", pending_total, 1);
        tick();
        grant = '0;
        check("stall_served2", served, 32'h1);
        check("stall_pending0", pending_total, 0);
        check("stall_errs", errs(), 0);

        // Push and retire together on client 7
        do_reset();
        push = 32'h80;
        tick();
        grant = 32'h80;
        tick();
        push = '0; grant = '0;
        check("simul_pending", pending_total, 1);
        check("simul_served", served, 32'h80);
        check("simul_request", request, 32'h80);
        check("simul_errs", errs(), 0);

        // Overflow and non-one-hot grant
        do_reset();
        push = 32'h4;
        repeat (15) tick();
        check("ovf_pending15", pending_total, 15);
        check("ovf_ready_low", push_ready[2], 0);
        check("ovf_flag_pre", err_overflow, 0);
        tick();
        push = '0;
        check("ovf_flag", err_overflow, 1);
        check("ovf_pending_sat", pending_total, 15);
        grant = 32'h3;
        tick();
        grant = '0;
        check("onehot_flag", err_onehot, 1);
        check("onehot_pending", pending_total, 15);
        check("onehot_served", served, 0);

        // Starvation of client 1 while client 0 is always granted and refilled
        do_reset();
        push = 32'h3;
        tick();
        check("starve_pending_pre", pending_total, 2);
        push = 32'h1; grant = 32'h1;
        repeat (31) tick();
        check("starve_flag_31", err_starve, 0);
        check("starve_pending_31", pending_total, 2);
        tick();
        check("starve_flag_32", err_starve, 1);
        check("starve_served", served, 32'h1);
        push = '0; grant = 32'h200;
        tick();
        grant = '0;
        check("unreq_flag", err_unreq, 1);
        check("unreq_onehot_clear", err_onehot, 0);
        check("unreq_served", served, 0);
        check("unreq_pending", pending_total, 2);
        tick();
        check("sticky_starve", err_starve, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
